dmem_port_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arb_wait_cnt.sv | 26 ++
 rtl/dmem_port_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: default widths,
// the starvation-counter geometry and the two-state host handshake encoding.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF        = 8;
  localparam int DATA_W_DEF        = 64;
  localparam int HOST_MAX_WAIT_DEF = 4;

  // Starvation counter is 4 bits wide and saturates at all-ones.
  localparam int              CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Host handshake: IDLE may grant the host, ACK returns data/ack for one cycle.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// Saturating starvation counter for a pending host request.
// Clear has priority over increment; the count sticks at CNT_MAX.
module dmem_arb_wait_cnt
  import dmem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count cycles the host loses; reset and clear both return to zero.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data-memory BRAM between the pipeline M stage
// (priority) and the host register interface. A host request is forced in
// after HOST_MAX_WAIT lost cycles, or at once while host_lock is held; when
// the host takes a cycle the M stage wanted, pl_stall freezes EX/M and earlier.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // pipeline M stage
  input  logic              pl_mem_en,
  input  logic              pl_we,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [DATA_W-1:0] pl_wdata,
  output logic              pl_stall,
  output logic [DATA_W-1:0] pl_rdata,
  // host register interface
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  // BRAM port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(HOST_MAX_WAIT);

  arb_state_t        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] host_rdata_q;
  logic              host_eligible;
  logic              host_grant;
  logic              pl_grant;

  // Grant decisions: the host only competes from IDLE, so back-to-back host
  // transactions are spaced by the ACK cycle, which the pipeline may use.
  assign host_eligible = host_req && (state == IDLE);
  assign host_grant    = host_eligible &&
                         (!pl_mem_en || host_lock || (wait_cnt >= MAX_WAIT));
  assign pl_grant      = pl_mem_en && !host_grant && !host_lock;

  // Stall is forced low during reset so the pipeline never sees a stale hold.
  assign pl_stall = !rst && pl_mem_en && !pl_grant;

  // Load data goes straight through; writeback samples it the cycle after grant.
  assign pl_rdata = mem_rdata;

  // Host data is live from the BRAM during ACK and held from a register after.
  assign host_rdata = host_ack ? mem_rdata : host_rdata_q;

  // Steer the BRAM port to whichever requester won this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pl_addr;
    mem_wdata = pl_wdata;
    if (!rst) begin
      if (host_grant) begin
        mem_en    = 1'b1;
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end else if (pl_grant) begin
        mem_en    = 1'b1;
        mem_we    = pl_we;
      end
    end
  end

  // Starvation counter: cleared when the host wins or withdraws, bumped on loss.
  dmem_arb_wait_cnt u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (host_grant || !host_req),
    .inc (host_eligible && !host_grant),
    .cnt (wait_cnt)
  );

  // Host handshake FSM with registered ack and held read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      host_ack     <= 1'b0;
      // NOTE: only the small holding register is reset; the BRAM contents are
      // never reset, so software must not rely on power-up memory values.
      host_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          host_ack <= host_grant;
          if (host_grant) state <= ACK;
        end
        ACK: begin
          host_ack     <= 1'b0;
          host_rdata_q <= mem_rdata;
          state        <= IDLE;
        end
        default: begin
          host_ack <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed scoreboard bench for dmem_port_arbiter. The driver applies one
// vector per cycle and queues the expected port values and response data;
// a negedge monitor pops and compares whenever the DUT presents a response.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          pl_mem_en, pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_wdata;
  logic          pl_stall;
  logic [DW-1:0] pl_rdata;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .pl_mem_en(pl_mem_en), .pl_we(pl_we), .pl_addr(pl_addr), .pl_wdata(pl_wdata),
    .pl_stall(pl_stall), .pl_rdata(pl_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_lock(host_lock),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural single-port BRAM, read-first, one-cycle read latency.
  logic [DW-1:0] mem_model [256];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem_model[mem_addr];
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stall;
    logic          ack;
  } cyc_exp_t;

  typedef struct {
    logic          chk;
    logic [DW-1:0] data;
  } host_exp_t;

  cyc_exp_t      cyc_q[$];
  host_exp_t     host_q[$];
  logic [DW-1:0] pl_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Queue this cycle's expected port values, then move to the next cycle.
  task automatic step(input logic en, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic stall, input logic ack);
    cyc_exp_t e;
    e.en = en; e.we = we; e.addr = addr; e.wdata = wdata; e.stall = stall; e.ack = ack;
    cyc_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pl(input logic en, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    pl_mem_en = en; pl_we = we; pl_addr = addr; pl_wdata = wdata;
  endtask

  task automatic drive_host(input logic req, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic lock);
    host_req = req; host_we = we; host_addr = addr; host_wdata = wdata; host_lock = lock;
  endtask

  task automatic exp_host(input logic chk, input logic [DW-1:0] data);
    host_exp_t h;
    h.chk = chk; h.data = data;
    host_q.push_back(h);
  endtask

  // Monitor: per-cycle port check, plus data checks triggered by host_ack and
  // by an observed pipeline load grant in the previous cycle.
  logic pl_load_prev = 1'b0;
  always @(negedge clk) begin
    cyc_exp_t  e;
    host_exp_t h;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check("mem_en", DW'(mem_en), DW'(e.en));
      check("mem_we", DW'(mem_we), DW'(e.we));
      if (e.en) check("mem_addr", DW'(mem_addr), DW'(e.addr));
      if (e.en && e.we) check("mem_wdata", mem_wdata, e.wdata);
      check("pl_stall", DW'(pl_stall), DW'(e.stall));
      check("host_ack", DW'(host_ack), DW'(e.ack));
    end
    if (host_ack === 1'b1) begin
      if (host_q.size() == 0) begin
        check("host_ack_unexpected", DW'(host_ack), '0);
      end else begin
        h = host_q.pop_front();
        if (h.chk) check("host_rdata", host_rdata, h.data);
      end
    end
    if (pl_load_prev) begin
      if (pl_q.size() == 0) check("pl_load_unexpected", DW'(1), DW'(0));
      else check("pl_rdata", pl_rdata, pl_q.pop_front());
    end
    pl_load_prev = (rst === 1'b0) && (pl_mem_en === 1'b1) &&
                   (pl_stall === 1'b0) && (pl_we === 1'b0);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = '0;
    mem_model[8'h05] = 64'h1234;

    rst = 1'b1;
    drive_pl(1'b1, 1'b0, 8'h00, '0);
    drive_host(1'b1, 1'b0, 8'h00, '0, 1'b0);
    @(posedge clk);
    #1;

    // Reset held with both requesting: port idle, no stall, no ack.
    check("rst_host_rdata", host_rdata, '0);
    step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0);

    // Pipeline store then load of 8'h10.
    rst = 1'b0;
    drive_host(1'b0, 1'b0, 8'h00, '0, 1'b0);
    drive_pl(1'b1, 1'b1, 8'h10, 64'hDEAD_BEEF_0000_0010);
    step(1'b1, 1'b1, 8'h10, 64'hDEAD_BEEF_0000_0010, 1'b0, 1'b0);
    drive_pl(1'b1, 1'b0, 8'h10, '0);
    pl_q.push_back(64'hDEAD_BEEF_0000_0010);
    step(1'b1, 1'b0, 8'h10, '0, 1'b0, 1'b0);
    drive_pl(1'b0, 1'b0, 8'h00, '0);
    step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0);

    // Host read of preloaded 8'h05 with the port idle.
    drive_host(1'b1, 1'b0, 8'h05, '0, 1'b0);
    exp_host(1'b1, 64'h1234);
    step(1'b1, 1'b0, 8'h05, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b1);
    drive_host(1'b0, 1'b0, 8'h00, '0, 1'b0);
    step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0);

    // Contention: pipeline wins four cycles, host forced on the fifth.
    drive_pl(1'b1, 1'b0, 8'h10, '0);
    drive_host(1'b1, 1'b0, 8'h05, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      pl_q.push_back(64'hDEAD_BEEF_0000_0010);
      step(1'b1, 1'b0, 8'h10, '0, 1'b0, 1'b0);
    end
    exp_host(1'b1, 64'h1234);
    step(1'b1, 1'b0, 8'h05, '0, 1'b1, 1'b0);
    drive_host(1'b0, 1'b0, 8'h00, '0, 1'b0);
    pl_q.push_back(64'hDEAD_BEEF_0000_0010);
    step(1'b1, 1'b0, 8'h10, '0, 1'b0, 1'b1);
    drive_pl(1'b0, 1'b0, 8'h00, '0);
    step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0);

    // Host lock: pipeline stalled every cycle, host grant/ack alternate.
    drive_pl(1'b1, 1'b0, 8'h10, '0);
    drive_host(1'b1, 1'b0, 8'h05, '0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      exp_host(1'b1, 64'h1234);
      step(1'b1, 1'b0, 8'h05, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, '0, 1'b1, 1'b1);
    end
    drive_pl(1'b0, 1'b0, 8'h00, '0);
    drive_host(1'b0, 1'b0, 8'h00, '0, 1'b0);
    step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0);

    // Reset asserted during the ACK cycle.
    drive_host(1'b1, 1'b0, 8'h05, '0, 1'b0);
    exp_host(1'b1, 64'h1234);
    step(1'b1, 1'b0, 8'h05, '0, 1'b0, 1'b0);
    rst = 1'b1;
    drive_host(1'b0, 1'b0, 8'h00, '0, 1'b0);
    step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b1);
    rst = 1'b0;
    check("rst_ack_state", 64'(dut.state), 64'(IDLE));
    check("rst_ack_wait_cnt", 64'(dut.wait_cnt), '0);
    step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0);
    drive_host(1'b1, 1'b0, 8'h05, '0, 1'b0);
    exp_host(1'b1, 64'h1234);
    step(1'b1, 1'b0, 8'h05, '0, 1'b0, 1'b0);
    drive_host(1'b0, 1'b0, 8'h00, '0, 1'b0);
    step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0);

    // Host write to 8'h20, pipeline loads it during the ACK cycle.
    drive_host(1'b1, 1'b1, 8'h20, 64'hAA, 1'b0);
    exp_host(1'b0, '0);
    step(1'b1, 1'b1, 8'h20, 64'hAA, 1'b0, 1'b0);
    drive_host(1'b0, 1'b0, 8'h00, '0, 1'b0);
    drive_pl(1'b1, 1'b0, 8'h20, '0);
    pl_q.push_back(64'hAA);
    step(1'b1, 1'b0, 8'h20, '0, 1'b0, 1'b1);
    drive_pl(1'b0, 1'b0, 8'h00, '0);
    step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0);

    // Every queued expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    check("cyc_q_drained", 64'(cyc_q.size()), '0);
    check("host_q_drained", 64'(host_q.size()), '0);
    check("pl_q_drained", 64'(pl_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
